button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 160 ++++++++++++++++
 tb/tb_button_conditioner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: debounces four colour buttons and a start button, then
// turns the debounced colours into a single accepted press (IN / IN_VALID).
// A second colour showing up is reported with a one-cycle MULTI_ERR pulse.
//
// Build option: define BTN_SYNC_EN to put a two-flop synchronizer in front of
// every debouncer, which adds two cycles of latency. Without it the raw pins
// feed the debouncers directly.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] BTN,
    input  logic       BTN_START,
    output logic [1:0] IN,
    output logic       IN_VALID,
    output logic       START_GAME,
    output logic       MULTI_ERR
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value seen on the last differing sample before a level flips.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Bit 4 is the start button, bits 3:0 are the colours.
    logic [4:0] raw_bus;
    logic [4:0] level;

    assign raw_bus = {BTN_START, BTN};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_chan
            logic sample;
            logic stable_reg;
            logic [CNT_W-1:0] cnt_reg;

`ifdef BTN_SYNC_EN
            logic meta_reg;
            logic sync_reg;

            // Two-flop synchronizer bringing the raw pin into the CLK domain.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= raw_bus[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sample = sync_reg;
`else
            assign sample = raw_bus[gi];
`endif

            // Debouncer: flip the stable level only after DEBOUNCE_CYCLES
            // consecutive samples disagree with it; any agreeing sample restarts.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else if (sample == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    stable_reg <= ~stable_reg;
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end

            assign level[gi] = stable_reg;
        end
    endgenerate

    logic [3:0] colors;
    logic [3:0] prev_colors_reg;
    logic [3:0] cap_mask;
    logic [3:0] new_rise;
    logic [1:0] color_idx;
    logic       one_hot;
    logic       any_color;

    state_t     state_reg;
    logic [1:0] in_reg;
    logic       in_valid_reg;
    logic       start_game_reg;
    logic       multi_err_reg;

    assign colors    = level[3:0];
    assign any_color = |colors;
    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign one_hot   = any_color && ((colors & (colors - 4'd1)) == 4'd0);
    // Binary index of the set bit; only meaningful when one_hot holds.
    assign color_idx = {colors[3] | colors[2], colors[3] | colors[1]};
    assign cap_mask  = 4'b0001 << in_reg;
    // Colours that went high this cycle, ignoring the one already captured.
    assign new_rise  = colors & ~prev_colors_reg & ~cap_mask;

    // Colour press FSM plus the registered start level; the two share nothing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= IDLE;
            in_reg          <= 2'd0;
            in_valid_reg    <= 1'b0;
            start_game_reg  <= 1'b0;
            multi_err_reg   <= 1'b0;
            prev_colors_reg <= 4'd0;
        end else begin
            start_game_reg  <= level[4];
            prev_colors_reg <= colors;
            multi_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (one_hot) begin
                        in_reg       <= color_idx;
                        in_valid_reg <= 1'b1;
                        state_reg    <= PRESSED;
                    end else if (any_color) begin
                        multi_err_reg <= 1'b1;
                        state_reg     <= DRAIN;
                    end
                end
                PRESSED: begin
                    if (|new_rise) begin
                        multi_err_reg <= 1'b1;
                    end
                    if (!colors[in_reg]) begin
                        in_valid_reg <= 1'b0;
                        state_reg    <= any_color ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (!any_color) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign IN         = in_reg;
    assign IN_VALID   = in_valid_reg;
    assign START_GAME = start_game_reg;
    assign MULTI_ERR  = multi_err_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4. Directed scenarios
// with fixed latency expectations, then random button activity compared
// cycle by cycle against a behavioural model built from the button rules.
module tb_button_conditioner;

    localparam int D = 4;
`ifdef BTN_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 0;
`endif
    localparam int LAT = D + 1 + SYNC_STAGES;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] BTN = 4'd0;
    logic       BTN_START = 1'b0;
    logic [1:0] IN;
    logic       IN_VALID;
    logic       START_GAME;
    logic       MULTI_ERR;

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BTN        (BTN),
        .BTN_START  (BTN_START),
        .IN         (IN),
        .IN_VALID   (IN_VALID),
        .START_GAME (START_GAME),
        .MULTI_ERR  (MULTI_ERR)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model state.
    logic [D-1:0] m_win [5];   // last D samples seen by each debouncer
    int           m_fill;      // samples seen since reset (window valid when >= D)
    logic [4:0]   m_stable;
    logic [4:0]   m_s1, m_s2;
    logic [3:0]   m_prev;
    logic [1:0]   m_in;
    logic         m_valid, m_start, m_err;
    int           m_st;        // 0 idle, 1 holding a press, 2 waiting for all released

    // Event trackers from observed outputs.
    logic p_valid = 1'b0, p_start = 1'b0;
    int valid_rises = 0, err_pulses = 0;
    int valid_rise_cyc = 0, valid_fall_cyc = 0, start_rise_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 5; ch++) m_win[ch] = '0;
        m_fill = 0; m_stable = '0; m_s1 = '0; m_s2 = '0; m_prev = '0;
        m_in = 2'd0; m_valid = 1'b0; m_start = 1'b0; m_err = 1'b0; m_st = 0;
    endtask

    // One rising edge of the model, using the inputs present before the edge.
    task automatic model_step();
        logic [4:0] raw, deb_in;
        logic [3:0] colors;
        int n;
        raw = {BTN_START, BTN};
        if (RST) begin
            model_reset();
        end else begin
            deb_in = (SYNC_STAGES > 0) ? m_s2 : raw;
            m_s2 = m_s1;
            m_s1 = raw;
            colors  = m_stable[3:0];
            m_start = m_stable[4];
            m_err   = 1'b0;
            n = $countones(colors);
            case (m_st)
                0: begin
                    if (n == 1) begin
                        for (int i = 0; i < 4; i++) if (colors[i]) m_in = 2'(i);
                        m_valid = 1'b1;
                        m_st = 1;
                    end else if (n >= 2) begin
                        m_err = 1'b1;
                        m_st = 2;
                    end
                end
                1: begin
                    for (int i = 0; i < 4; i++)
                        if (i != int'(m_in) && colors[i] && !m_prev[i]) m_err = 1'b1;
                    if (!colors[m_in]) begin
                        m_valid = 1'b0;
                        m_st = (n == 0) ? 0 : 2;
                    end
                end
                default: begin
                    if (n == 0) m_st = 0;
                end
            endcase
            m_prev = colors;
            // A level flips once the last D samples all disagree with it.
            m_fill++;
            for (int ch = 0; ch < 5; ch++) begin
                m_win[ch] = {m_win[ch][D-2:0], deb_in[ch]};
                if (m_fill >= D && m_win[ch] == {D{~m_stable[ch]}})
                    m_stable[ch] = ~m_stable[ch];
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        cyc++;
        chk("IN", 32'(IN), 32'(m_in));
        chk("IN_VALID", 32'(IN_VALID), 32'(m_valid));
        chk("START_GAME", 32'(START_GAME), 32'(m_start));
        chk("MULTI_ERR", 32'(MULTI_ERR), 32'(m_err));
        if (IN_VALID === 1'b1 && p_valid !== 1'b1) begin valid_rises++; valid_rise_cyc = cyc; end
        if (IN_VALID === 1'b0 && p_valid === 1'b1) valid_fall_cyc = cyc;
        if (START_GAME === 1'b1 && p_start !== 1'b1) start_rise_cyc = cyc;
        if (MULTI_ERR === 1'b1) err_pulses++;
        p_valid = IN_VALID;
        p_start = START_GAME;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int e0;
        logic [4:0] flip;
        int noisy;
        model_reset();

        // Reset state.
        RST = 1'b1; run(3);
        chk("rst_in", 32'(IN), 32'd0);
        chk("rst_valid", 32'(IN_VALID), 32'd0);
        chk("rst_start", 32'(START_GAME), 32'd0);
        chk("rst_err", 32'(MULTI_ERR), 32'd0);
        RST = 1'b0; run(2);

        // Single colour press and release.
        valid_rises = 0; BTN = 4'b0100; e0 = cyc; run(10);
        chk("t30_rises", 32'(valid_rises), 32'd1);
        chk("t30_rise_lat", 32'(valid_rise_cyc - e0), 32'(LAT));
        chk("t30_in", 32'(IN), 32'd2);
        BTN = 4'b0000; e0 = cyc; run(10);
        chk("t30_fall_lat", 32'(valid_fall_cyc - e0), 32'(LAT));
        chk("t30_in_hold", 32'(IN), 32'd2);

        // Short glitch is rejected.
        valid_rises = 0; BTN = 4'b0010; run(3); BTN = 4'b0000; run(10);
        chk("t31_rises", 32'(valid_rises), 32'd0);
        chk("t31_in", 32'(IN), 32'd2);

        // Second colour during a press, then drain.
        BTN = 4'b0001; run(10);
        chk("t32_valid", 32'(IN_VALID), 32'd1);
        valid_rises = 0; err_pulses = 0;
        BTN = 4'b1001; run(10);
        chk("t32_err", 32'(err_pulses), 32'd1);
        chk("t32_in", 32'(IN), 32'd0);
        chk("t32_valid_held", 32'(IN_VALID), 32'd1);
        BTN = 4'b1000; run(10);
        chk("t32_drop", 32'(IN_VALID), 32'd0);
        BTN = 4'b0000; run(10);
        chk("t32_no_second", 32'(valid_rises), 32'd0);

        // Simultaneous colours.
        valid_rises = 0; err_pulses = 0;
        BTN = 4'b0011; run(10);
        chk("t33_err", 32'(err_pulses), 32'd1);
        chk("t33_rises", 32'(valid_rises), 32'd0);
        BTN = 4'b0000; run(10);

        // Start and colour together.
        BTN = 4'b1000; BTN_START = 1'b1; e0 = cyc; run(8);
        chk("t34_start_lat", 32'(start_rise_cyc - e0), 32'(LAT));
        chk("t34_valid_lat", 32'(valid_rise_cyc - e0), 32'(LAT));
        chk("t34_in", 32'(IN), 32'd3);
        BTN = 4'b0000; BTN_START = 1'b0; run(10);

        // Reset in the middle of a held press.
        BTN = 4'b1000; run(LAT + 2);
        chk("t35_valid", 32'(IN_VALID), 32'd1);
        RST = 1'b1; cycle();
        chk("t35_rst_drop", 32'(IN_VALID), 32'd0);
        RST = 1'b0; e0 = cyc; valid_rises = 0; run(LAT + 3);
        chk("t35_rises", 32'(valid_rises), 32'd1);
        chk("t35_relat", 32'(valid_rise_cyc - e0), 32'(LAT));
        BTN = 4'b0000; run(10);

        // Random activity, alternating calm and bouncy stretches.
        for (int i = 0; i < 3000; i++) begin
            noisy = (i / 200) % 2;
            for (int b = 0; b < 5; b++)
                flip[b] = ($urandom_range(0, (noisy != 0) ? 3 : 24) == 0);
            BTN = BTN ^ flip[3:0];
            BTN_START = BTN_START ^ flip[4];
            RST = ($urandom_range(0, 499) == 0);
            cycle();
        end
        RST = 1'b0; BTN = 4'b0000; BTN_START = 1'b0; run(12);
        chk("final_valid", 32'(IN_VALID), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
